// File: rtl/seq_game_pkg.sv
// Shared types and defaults for the memory-game sequence playback slice.
// State encoding, default widths and the symbol one-hot decode helper.
package seq_game_pkg;

  localparam int unsigned LEN_W_DEF = 4;
  localparam int unsigned SYM_W_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SHOW   = 3'd3,
    ST_GAP    = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  function automatic logic [2**SYM_W_DEF-1:0] sym_onehot(input logic [SYM_W_DEF-1:0] sym);
    logic [2**SYM_W_DEF-1:0] oh;
    oh      = '0;
    oh[sym] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/seq_sym_decode.sv
// Binary symbol to one-hot LED pattern; blank_i forces all LEDs off.
module seq_sym_decode
  import seq_game_pkg::*;
#(
  parameter int unsigned SYM_W = SYM_W_DEF
) (
  input  logic [SYM_W-1:0]    sym_i,
  input  logic                blank_i,
  output logic [2**SYM_W-1:0] led_o
);

  logic [2**SYM_W-1:0] oh;

  generate
    if (SYM_W == SYM_W_DEF) begin : g_pkg
      assign oh = sym_onehot(sym_i);
    end else begin : g_loop
      always_comb begin
        oh        = '0;
        oh[sym_i] = 1'b1;
      end
    end
  endgenerate

  assign led_o = blank_i ? '0 : oh;

endmodule

// File: rtl/seq_playback_ctrl.sv
// Plays a stored sequence on the LEDs, pacing each lit/blank phase with an external interval timer.
// Optional build macro SEQ_PLAYBACK_LOOP_EN adds a loop input that restarts playback instead of finishing.
module seq_playback_ctrl
  import seq_game_pkg::*;
#(
  parameter int unsigned LEN_W         = LEN_W_DEF,
  parameter int unsigned SYM_W         = SYM_W_DEF,
  parameter int unsigned ON_INTERVALS  = 2,
  parameter int unsigned OFF_INTERVALS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [LEN_W-1:0]    seq_len,
`ifdef SEQ_PLAYBACK_LOOP_EN
  input  logic                loop,
`endif
  output logic [LEN_W-1:0]    mem_addr,
  input  logic [SYM_W-1:0]    mem_data,
  output logic                tmr_en,
  output logic                tmr_rst_n,
  input  logic                tmr_done,
  output logic [2**SYM_W-1:0] led,
  output logic                busy,
  output logic                done
);

  localparam int unsigned LEDS   = 2**SYM_W;
  localparam int unsigned PH_MAX = (ON_INTERVALS > OFF_INTERVALS) ? ON_INTERVALS : OFF_INTERVALS;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  addr_q, addr_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic [LEDS-1:0]   led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ten_q, ten_d;
  logic              trst_q, trst_d;
  logic              loop_en;
  logic [LEDS-1:0]   dec_led;

`ifdef SEQ_PLAYBACK_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      ph_q    <= '0;
      sym_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ten_q   <= 1'b0;
      trst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;
      sym_q   <= sym_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ten_q   <= ten_d;
      trst_q  <= trst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    ph_d    = ph_q;
    sym_d   = sym_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (seq_len != '0) begin
              len_d   = seq_len;
              idx_d   = '0;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_FINISH;
            end
          end
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          sym_d   = mem_data;
          ph_d    = '0;
          state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (tmr_done) begin
            if (ph_q == PH_W'(ON_INTERVALS - 1)) begin
              ph_d    = '0;
              state_d = ST_GAP;
            end else begin
              ph_d = ph_q + PH_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (tmr_done) begin
            if (ph_q == PH_W'(OFF_INTERVALS - 1)) begin
              ph_d = '0;
              if (idx_q == (len_q - LEN_W'(1))) begin
                if (loop_en) begin
                  idx_d   = '0;
                  state_d = ST_FETCH;
                end else begin
                  state_d = ST_FINISH;
                end
              end else begin
                idx_d   = idx_q + LEN_W'(1);
                state_d = ST_FETCH;
              end
            end else begin
              ph_d = ph_q + PH_W'(1);
            end
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  seq_sym_decode #(
    .SYM_W (SYM_W)
  ) u_decode (
    .sym_i   (sym_d),
    .blank_i (state_d != ST_SHOW),
    .led_o   (dec_led)
  );

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    addr_d = (state_d == ST_FETCH) ? idx_d : addr_q;
    led_d  = dec_led;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
    ten_d  = (state_d == ST_SHOW) || (state_d == ST_GAP);
    trst_d = (state_d == ST_SHOW) || (state_d == ST_GAP);
  end

  assign mem_addr  = addr_q;
  assign led       = led_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tmr_en    = ten_q;
  assign tmr_rst_n = trst_q;

endmodule
